fdiv_mant_seq_ctrl: RTL

//  Multi-cycle sequencer for the FPU mantissa divider. Performs one unsigned restoring-division

---
 rtl/fdiv_mant_seq_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fdiv_mant_seq_ctrl.sv
// rtl/fdiv_mant_seq_ctrl.sv - sequential restoring mantissa divider, one quotient bit per clock
module fdiv_mant_seq_ctrl #(
  parameter int WIDTH = 51,
  parameter int ITER  = 51,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ma_in,
  input  logic [WIDTH-1:0] mb_in,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   p_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH:0]   t_diff;
  logic [WIDTH:0]   p_nx;
  logic [WIDTH-1:0] a_nx;
  logic             last_step;

  // P carries one extra bit so a divisor with its MSB set still subtracts exactly.
  always_comb begin
    p_sh      = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    a_sh      = a_q << 1;
    t_diff    = p_sh - {1'b0, b_q};
    p_nx      = p_sh;
    a_nx      = a_sh;
    if (!t_diff[WIDTH]) begin
      p_nx = t_diff;
      a_nx = a_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end
    last_step = (cnt == CW'(ITER - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= ma_in;
            b_q      <= mb_in;
            p_q      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (mb_in == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= ma_in;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          a_q <= a_nx;
          p_q <= p_nx;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            state     <= DONE;
            quotient  <= a_nx;
            remainder <= p_nx[WIDTH-1:0];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // The step counter must never run past the final step.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RUN) |-> (cnt < CW'(ITER)));

endmodule
